// File: rtl/led_sched_pkg.sv
// ---------------------------------------------------------------------------
// led_sched_pkg: shared state encoding and default timing constants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_SENDING   = 3'd4
  } sched_state_e;

  // 60 Hz frame period and a generous PHY watchdog at a 150 MHz pixel clock
  localparam int unsigned DEF_MIN_PERIOD = 2_500_000;
  localparam int unsigned DEF_TIMEOUT    = 1_500_000;

endpackage

`default_nettype wire

// File: rtl/sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt: up-counter that sticks at all-ones, with synchronous clear. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/led_frame_sched.sv
// ---------------------------------------------------------------------------
// led_frame_sched: gates frame starts by a minimum period and watches the LED PHY. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_frame_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             frame_valid,
  input  logic             phy_busy,
  output logic             start,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [2:0]       state_o
);

  localparam logic [PERIOD_W-1:0] PERIOD_RELOAD = PERIOD_W'(MIN_PERIOD - 1);
  localparam logic [PERIOD_W-1:0] WD_RELOAD     = PERIOD_W'(TIMEOUT - 1);

  sched_state_e        state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] wd_q, wd_d;
  logic                stop_pend_q, stop_pend_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic period_ok;
  logic wd_expired;
  logic in_xfer;
  logic accept;
  logic drop;
  logic to_err;

  assign period_ok  = (period_q == '0);
  assign wd_expired = (wd_q == '0);
  assign in_xfer    = (state_q == ST_ISSUE) || (state_q == ST_WAIT_BUSY) ||
                      (state_q == ST_SENDING);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = in_xfer && frame_valid;
    done_d  = 1'b0;
    to_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !stop) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (frame_valid) begin
          if (period_ok) begin
            accept  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (phy_busy) begin
          state_d = ST_SENDING;
        end else if (wd_expired) begin
          to_err  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SENDING: begin
        if (!phy_busy) begin
          done_d  = 1'b1;
          state_d = (oneshot || stop_pend_q || stop) ? ST_IDLE : ST_ARMED;
        end else if (wd_expired) begin
          to_err  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    start   = (state_q == ST_ISSUE);
    state_o = state_q;
  end

  // Period counter, watchdog, pending stop, sticky error
  always_comb begin
    period_d = period_ok ? period_q : (period_q - PERIOD_W'(1));
    if (accept) period_d = PERIOD_RELOAD;

    wd_d = wd_expired ? wd_q : (wd_q - PERIOD_W'(1));
    if ((state_q == ST_ISSUE) || ((state_q == ST_WAIT_BUSY) && phy_busy)) begin
      wd_d = WD_RELOAD;
    end

    stop_pend_d = stop_pend_q;
    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
    end else if (in_xfer && stop) begin
      stop_pend_d = 1'b1;
    end

    err_d = err_q;
    if (to_err) begin
      err_d = 1'b1;
    end else if (en) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q    <= '0;
      wd_q        <= '0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      period_q    <= period_d;
      wd_q        <= wd_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign frame_done  = done_q;
  assign timeout_err = err_q;

  sat_cnt #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (done_d),
    .clr_i (1'b0),
    .cnt_o (frame_cnt)
  );

  sat_cnt #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop),
    .clr_i (1'b0),
    .cnt_o (drop_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_led_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_led_frame_sched: scoreboard bench against a timestamp-based reference. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_frame_sched;

  localparam int unsigned PERIOD_W   = 8;
  localparam int unsigned MIN_PERIOD = 50;
  localparam int unsigned TIMEOUT    = 30;
  localparam int unsigned CNT_W      = 2;
  localparam int          CMAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, stop, oneshot, frame_valid, phy_busy;
  logic             start, frame_done, timeout_err;
  logic [CNT_W-1:0] frame_cnt, drop_cnt;
  logic [2:0]       state_o;

  led_frame_sched #(
    .PERIOD_W  (PERIOD_W),
    .MIN_PERIOD(MIN_PERIOD),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stop       (stop),
    .oneshot    (oneshot),
    .frame_valid(frame_valid),
    .phy_busy   (phy_busy),
    .start      (start),
    .frame_done (frame_done),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [2:0]       st;
    logic             start;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] dc;
  } snap_t;

  snap_t snap_q[$];
  snap_t mon_exp;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    os_lvl = 1'b0;
  bit    busy_lvl = 1'b0;

  // Reference: 0 idle, 1 armed, 2 issue, 3 wait busy, 4 sending; timing via timestamps
  int m_st = 0;
  bit m_have = 1'b0;
  int m_last = 0;
  int m_entry = 0;
  bit m_pend = 1'b0;
  bit m_err = 1'b0;
  bit m_done = 1'b0;
  int m_fc = 0;
  int m_dc = 0;

  task automatic model_cycle(input bit r, input bit e, input bit s, input bit o,
                             input bit f, input bit b);
    snap_t sn;
    int    nxt;
    bit    to_err;
    if (r) begin
      m_st = 0; m_have = 1'b0; m_pend = 1'b0; m_err = 1'b0;
      m_done = 1'b0; m_fc = 0; m_dc = 0;
    end
    sn.cyc   = cyc;
    sn.st    = 3'(m_st);
    sn.start = (m_st == 2);
    sn.done  = m_done;
    sn.err   = m_err;
    sn.fc    = CNT_W'(m_fc);
    sn.dc    = CNT_W'(m_dc);
    snap_q.push_back(sn);
    if (r) return;

    nxt    = m_st;
    to_err = 1'b0;
    m_done = 1'b0;
    if (m_st >= 2 && f && m_dc < CMAX) m_dc++;
    case (m_st)
      0: if (e && !s) nxt = 1;
      1: begin
        if (s) begin
          nxt = 0;
        end else if (f) begin
          // a start at cyc+1 must lie at least MIN_PERIOD after the previous one
          if (!m_have || (cyc + 1 - m_last) >= int'(MIN_PERIOD)) begin
            nxt = 2; m_have = 1'b1; m_last = cyc + 1;
          end else if (m_dc < CMAX) begin
            m_dc++;
          end
        end
      end
      2: begin nxt = 3; m_entry = cyc + 1; end
      3: begin
        if (b) begin
          nxt = 4; m_entry = cyc + 1;
        end else if (cyc - m_entry >= int'(TIMEOUT) - 1) begin
          nxt = 0; to_err = 1'b1;
        end
      end
      4: begin
        if (!b) begin
          m_done = 1'b1;
          if (m_fc < CMAX) m_fc++;
          nxt = (o || m_pend || s) ? 0 : 1;
        end else if (cyc - m_entry >= int'(TIMEOUT) - 1) begin
          nxt = 0; to_err = 1'b1;
        end
      end
      default: nxt = 0;
    endcase
    if (m_st >= 2 && s) m_pend = 1'b1;
    if (nxt == 0) m_pend = 1'b0;
    if (to_err) m_err = 1'b1;
    else if (e) m_err = 1'b0;
    m_st = nxt;
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit f);
    rst = r; en = e; stop = s; oneshot = os_lvl; frame_valid = f; phy_busy = busy_lvl;
    model_cycle(r, e, s, os_lvl, f, busy_lvl);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit b);
    busy_lvl = b;
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (snap_q.size() != 0) begin
      mon_exp = snap_q.pop_front();
      checks++;
      if (state_o !== mon_exp.st || start !== mon_exp.start || frame_done !== mon_exp.done ||
          timeout_err !== mon_exp.err || frame_cnt !== mon_exp.fc || drop_cnt !== mon_exp.dc) begin
        errors++;
        $display("FAIL outputs cyc=%0d got st=%0d start=%0b done=%0b err=%0b fcnt=%0d dcnt=%0d expected st=%0d start=%0b done=%0b err=%0b fcnt=%0d dcnt=%0d",
                 mon_exp.cyc, state_o, start, frame_done, timeout_err, frame_cnt, drop_cnt,
                 mon_exp.st, mon_exp.start, mon_exp.done, mon_exp.err, mon_exp.fc, mon_exp.dc);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; stop = 1'b0; oneshot = 1'b0; frame_valid = 1'b0; phy_busy = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

    // first frame goes immediately, full transfer back to ARMED
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(100, 1'b1);
    idle(5, 1'b0);

    // early frame dropped, frame 60 cycles after start accepted
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(5, 1'b1);
    idle(13, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(39, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(4, 1'b1);
    idle(3, 1'b0);

    // watchdog in WAIT_BUSY, then en clears the error
    idle(55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(40, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // stop while sending: transfer completes, then IDLE ignores frames
    idle(55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    idle(3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // oneshot, then en+stop together in IDLE
    os_lvl = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(3, 1'b1);
    idle(4, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);
    os_lvl = 1'b0;

    // drop saturation, then reset mid-transfer
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // randomized traffic with a wandering PHY busy level
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) os_lvl = ~os_lvl;
      if (!busy_lvl) busy_lvl = ($urandom_range(0, 5) == 0);
      else           busy_lvl = ($urandom_range(0, 19) != 0);
      step($urandom_range(0, 599) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0);
    end
    idle(2, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (snap_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples left, required 0", snap_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
